// File: rtl/fb_cursor_writer.sv
// Frame-buffer cursor writer: clears a 64-cell RGB222 buffer, draws a cursor cell and
// moves it one cell per debounced left/right button press. Moves are issued only during
// vertical blanking so the display never shows a half-updated frame.
module fb_cursor_writer #(
    parameter int unsigned     AW        = 6,
    parameter int unsigned     DW        = 6,
    parameter int unsigned     DEPTH     = 64,
    parameter logic [DW-1:0]   BG_COLOR  = 6'b000000,
    parameter logic [DW-1:0]   CUR_COLOR = 6'b110000,
    parameter int unsigned     DB_CYCLES = 250000,
    parameter int unsigned     DB_W      = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bntl,
    input  logic          bntr,
    input  logic          vblank,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic [AW-1:0] cursor_pos,
    output logic          busy
);

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StWaitVb,
        StErase,
        StDraw
    } state_e;

    localparam logic [DB_W-1:0] DbLast  = DB_W'(DB_CYCLES - 1);
    localparam logic [AW-1:0]   LastIdx = AW'(DEPTH - 1);

    // Button path, bit 0 = left, bit 1 = right.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            lvl_q, lvl_d;
    logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [1:0]            press;

    // Single-entry request latch.
    logic                  req_valid_q, req_valid_d;
    logic                  req_right_q, req_right_d;

    // Writer state.
    state_e                state_q, state_d;
    logic [AW-1:0]         clr_idx_q, clr_idx_d;
    logic [AW-1:0]         target_q, target_d;
    logic [AW-1:0]         cursor_q, cursor_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  busy_q, busy_d;

    // Synchronise, debounce and edge-detect both buttons.
    always_comb begin
        sync1_d = {bntr, bntl};
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = '0;
        press   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                // Accept the new level on the DB_CYCLES-th consecutive differing cycle.
                if (cnt_q[i] == DbLast) begin
                    lvl_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Latch one request; simultaneous presses, presses while pending and during clear are lost.
    always_comb begin
        req_valid_d = req_valid_q;
        req_right_d = req_right_q;
        if (state_q == StErase) begin
            req_valid_d = 1'b0;
        end else if (state_q != StClear && !req_valid_q && (press == 2'b01 || press == 2'b10)) begin
            req_valid_d = 1'b1;
            req_right_d = press[1];
        end
    end

    // Writer FSM next state and registered write-port outputs.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        target_d  = target_q;
        cursor_d  = cursor_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        unique case (state_q)
            StClear: begin
                wr_d      = 1'b1;
                addr_d    = clr_idx_q;
                data_d    = BG_COLOR;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LastIdx) begin
                    state_d  = StDraw;
                    target_d = cursor_q;
                end
            end
            StIdle: begin
                if (req_valid_q) begin
                    state_d = StWaitVb;
                end
            end
            StWaitVb: begin
                if (vblank) begin
                    state_d = StErase;
                end
            end
            StErase: begin
                wr_d     = 1'b1;
                addr_d   = cursor_q;
                data_d   = BG_COLOR;
                // AW-bit arithmetic wraps modulo DEPTH.
                target_d = req_right_q ? cursor_q + 1'b1 : cursor_q - 1'b1;
                state_d  = StDraw;
            end
            StDraw: begin
                wr_d     = 1'b1;
                addr_d   = target_q;
                data_d   = CUR_COLOR;
                cursor_d = target_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_right_q <= 1'b0;
            state_q     <= StClear;
            clr_idx_q   <= '0;
            target_q    <= '0;
            cursor_q    <= '0;
            addr_q      <= '0;
            data_q      <= BG_COLOR;
            wr_q        <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lvl_q       <= lvl_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            req_right_q <= req_right_d;
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            target_q    <= target_d;
            cursor_q    <= cursor_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign cursor_pos  = cursor_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fb_cursor_writer.sv
// Self-checking bench for fb_cursor_writer: directed scenarios plus random moves checked
// against a cell-position model and a shadow copy of the frame buffer.
module tb_fb_cursor_writer;

    localparam logic [5:0] BG  = 6'b000000;
    localparam logic [5:0] CUR = 6'b110000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bntl = 1'b0;
    logic       bntr = 1'b0;
    logic       vblank = 1'b0;
    logic [5:0] mem_px_addr;
    logic [5:0] mem_px_data;
    logic       px_wr;
    logic [5:0] cursor_pos;
    logic       busy;

    fb_cursor_writer #(
        .AW        (6),
        .DW        (6),
        .DEPTH     (64),
        .BG_COLOR  (BG),
        .CUR_COLOR (CUR),
        .DB_CYCLES (4),
        .DB_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bntl        (bntl),
        .bntr        (bntr),
        .vblank      (vblank),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .cursor_pos  (cursor_pos),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        wq[$];
    int         cyc = 0;
    logic [5:0] shadow [64];
    int         passed = 0;
    int         total = 0;
    int         exp_pos = 0;

    // Write monitor: records every strobed write and mirrors it into a shadow buffer.
    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 6'h2a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (px_wr === 1'b1) begin
                wq.push_back('{int'(mem_px_addr), int'(mem_px_data), cyc});
                shadow[mem_px_addr] = mem_px_data;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit right, input int hold);
        if (right) bntr = 1'b1;
        else bntl = 1'b1;
        tick(hold);
        bntr = 1'b0;
        bntl = 1'b0;
        tick(10);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    // Model: a move erases the old cell, then draws the neighbour modulo 64.
    task automatic check_move(input string tag, input bit right);
        int old_pos;
        int new_pos;
        old_pos = exp_pos;
        new_pos = right ? (old_pos + 1) % 64 : (old_pos + 63) % 64;
        chk({tag, "_nwrites"}, wq.size(), 2);
        if (wq.size() >= 2) begin
            chk({tag, "_erase_addr"}, wq[0].addr, old_pos);
            chk({tag, "_erase_data"}, wq[0].data, int'(BG));
            chk({tag, "_draw_addr"}, wq[1].addr, new_pos);
            chk({tag, "_draw_data"}, wq[1].data, int'(CUR));
            chk({tag, "_back2back"}, wq[1].cyc - wq[0].cyc, 1);
        end
        exp_pos = new_pos;
        chk({tag, "_cursor"}, 32'(cursor_pos), exp_pos);
    endtask

    task automatic do_move(input string tag, input bit right, input int vb_delay, input int hold);
        wq.delete();
        vblank = (vb_delay == 0);
        press(right, hold);
        if (vb_delay > 0) begin
            tick(vb_delay);
            chk({tag, "_waitvb_busy"}, 32'(busy), 1);
            chk({tag, "_waitvb_nowr"}, wq.size(), 0);
            vblank = 1'b1;
        end
        wait_idle(tag, 50);
        vblank = 1'b0;
        tick(2);
        check_move(tag, right);
    endtask

    task automatic check_frame(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (shadow[i] !== ((i == exp_pos) ? CUR : BG)) bad++;
        end
        chk({tag, "_frame_bad_cells"}, bad, 0);
        chk({tag, "_frame_cursor_cell"}, 32'(shadow[exp_pos]), 32'(CUR));
    endtask

    // Release reset and check the 64-write clear plus the cursor draw at cell 0.
    task automatic release_and_check_clear(input string tag);
        int rel;
        int bad;
        wq.delete();
        rst = 1'b1;
        rel = cyc;
        tick(64);
        chk({tag, "_busy_during"}, 32'(busy), 1);
        tick(1);
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_cursor"}, 32'(cursor_pos), 0);
        chk({tag, "_nwrites"}, wq.size(), 65);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 65; i++) begin
            if (wq[i].addr != ((i < 64) ? i : 0)) bad++;
            if (wq[i].data != ((i < 64) ? int'(BG) : int'(CUR))) bad++;
            if (wq[i].cyc != rel + 1 + i) bad++;
        end
        chk({tag, "_seq_bad"}, bad, 0);
        exp_pos = 0;
        check_frame(tag);
    endtask

    initial begin
        int dir;
        int dly;
        int hold;
        int steps;

        // Reset values while rst is held low.
        tick(3);
        chk("rst_px_wr", 32'(px_wr), 0);
        chk("rst_addr", 32'(mem_px_addr), 0);
        chk("rst_data", 32'(mem_px_data), 32'(BG));
        chk("rst_cursor", 32'(cursor_pos), 0);
        chk("rst_busy", 32'(busy), 1);

        release_and_check_clear("clear");

        // Right press without vblank waits, then moves 0 -> 1.
        do_move("right_wait", 1'b1, 8, 10);
        // Left presses during vblank: 1 -> 0 -> 63, then right wraps 63 -> 0.
        do_move("left1", 1'b0, 0, 10);
        do_move("left_wrap", 1'b0, 0, 10);
        do_move("right_wrap", 1'b1, 0, 10);

        // Bouncing button never reaches a stable accepted level.
        wq.delete();
        vblank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bntr = 1'b1;
            tick(2);
            bntr = 1'b0;
            tick(2);
        end
        tick(12);
        chk("bounce_nowr", wq.size(), 0);
        chk("bounce_busy", 32'(busy), 0);

        // Both buttons together are ignored.
        bntl = 1'b1;
        bntr = 1'b1;
        tick(10);
        bntl = 1'b0;
        bntr = 1'b0;
        tick(12);
        chk("both_nowr", wq.size(), 0);
        chk("both_busy", 32'(busy), 0);
        chk("both_cursor", 32'(cursor_pos), exp_pos);

        // Second press while one is pending is dropped.
        wq.delete();
        vblank = 1'b0;
        press(1'b1, 10);
        press(1'b1, 10);
        tick(5);
        chk("dbl_waitvb_busy", 32'(busy), 1);
        chk("dbl_waitvb_nowr", wq.size(), 0);
        vblank = 1'b1;
        wait_idle("dbl", 50);
        vblank = 1'b0;
        tick(10);
        chk("dbl_no_second_req", 32'(busy), 0);
        check_move("dbl", 1'b1);

        // Random moves with random vblank delay and press length.
        for (int i = 0; i < 12; i++) begin
            dir  = $urandom_range(0, 1);
            dly  = $urandom_range(0, 12);
            hold = $urandom_range(8, 14);
            do_move($sformatf("rnd%0d", i), dir[0], dly, hold);
        end
        check_frame("rnd");

        // Walk to cell 5 along the shorter way round.
        steps = 0;
        while (exp_pos != 5 && steps < 40) begin
            do_move("walk", (((5 - exp_pos) & 63) <= 32), 0, 10);
            steps++;
        end
        chk("walk_cursor", 32'(cursor_pos), 5);

        // Reset while waiting for vblank aborts and forgets the request.
        wq.delete();
        vblank = 1'b0;
        press(1'b1, 10);
        chk("mid_waitvb_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_px_wr", 32'(px_wr), 0);
        chk("mid_rst_addr", 32'(mem_px_addr), 0);
        chk("mid_rst_data", 32'(mem_px_data), 32'(BG));
        chk("mid_rst_cursor", 32'(cursor_pos), 0);
        chk("mid_rst_busy", 32'(busy), 1);
        tick(3);
        release_and_check_clear("reclear");
        wq.delete();
        vblank = 1'b1;
        tick(30);
        chk("reclear_no_pending_wr", wq.size(), 0);
        chk("reclear_no_pending_busy", 32'(busy), 0);
        chk("reclear_cursor", 32'(cursor_pos), 0);

        // One more move after the re-clear.
        do_move("post_rst", 1'b0, 3, 10);
        check_frame("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_cursor_writer.md
Name: fb_cursor_writer

Overview:
- Owns the write port of the 64-entry, 6-bit (RGB 222) dual-port frame buffer (addr_in/data_in/regwrite).
- After reset it clears the buffer to a background colour, then draws a single cursor cell.
- Debounced left/right button presses move the cursor one cell at a time.
- Writes are scheduled into vertical blanking so the VGA read side never shows a half-updated frame.

Parameters:
- AW, 6, frame-buffer address width.
- DW, 6, pixel data width (RGB 222).
- DEPTH, 64, number of cells; must equal 2**AW.
- BG_COLOR, 6'b000000, background colour.
- CUR_COLOR, 6'b110000, cursor colour (red).
- DB_CYCLES, 250000, number of stable clk cycles before a button level is accepted (10 ms at 25 MHz).
- DB_W, 18, debounce counter width; must satisfy 2**DB_W > DB_CYCLES.

Ports:
- clk  in  1  pixel clock (25 MHz domain, same clock as the buffer write port).
- rst  in  1  reset; asynchronous, active-low.
- bntl  in  1  left button, raw and asynchronous.
- bntr  in  1  right button, raw and asynchronous.
- vblank  in  1  high during VGA vertical blanking, synchronous to clk.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  buffer write data.
- px_wr  out  1  buffer write strobe.
- cursor_pos  out  AW  current cursor cell.
- busy  out  1  high when state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: px_wr=0, mem_px_addr=0, mem_px_data=BG_COLOR, cursor_pos=0, busy=1, state=CLEAR, no pending request.
- Reset asserted mid-operation aborts immediately. After release the full CLEAR sequence restarts and the cursor returns to 0.
- Write protocol:
  - px_wr is high for exactly one cycle per write.
  - mem_px_addr and mem_px_data are valid in the same cycle as px_wr.
  - No write is issued in IDLE or WAIT_VB.
- Button path (each button independently):
  - 2-flop synchroniser, then debounce counter.
  - The accepted level changes only after DB_CYCLES consecutive cycles at the new value.
  - A press is the rising edge of the accepted level: a one-cycle pulse.
- Request latch:
  - One pending request (valid plus direction).
  - Left and right pulses in the same cycle: both ignored.
  - A pulse arriving while a request is already pending: dropped.
  - A pulse arriving during CLEAR: dropped.
- States:
  - CLEAR:
    - One write per cycle, addr 0..DEPTH-1, data BG_COLOR; does not wait for vblank.
    - After the write to DEPTH-1, go to DRAW with target = cursor_pos (0).
  - IDLE: if a request is pending, go to WAIT_VB.
  - WAIT_VB: hold until vblank=1, then go to ERASE.
  - ERASE:
    - Write BG_COLOR at cursor_pos.
    - Compute target = cursor_pos+1 (right) or cursor_pos-1 (left), modulo DEPTH: 63+1 gives 0, 0-1 gives 63.
    - Clear the pending request; go to DRAW.
  - DRAW:
    - Write CUR_COLOR at target; cursor_pos <= target; go to IDLE.
    - ERASE to DRAW is atomic: DRAW executes even if vblank falls in between.
- Latency:
  - Reset release to busy=0 is DEPTH+1 cycles (DEPTH clears, 1 draw).
  - vblank seen high in WAIT_VB to the ERASE write is 1 cycle; the DRAW write follows on the next cycle.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Bench note: all scenarios use DB_CYCLES=4.
- Release rst, hold vblank=0 -> px_wr high for 64 consecutive cycles with addr 0..63 and data 000000. Next cycle: addr 0, data 110000. Then busy=0 and cursor_pos=0.
- Pulse bntr high for 10 cycles with vblank=0 -> no px_wr and busy=1 (WAIT_VB). Raise vblank -> writes (0,000000) then (1,110000); cursor_pos=1; busy=0.
- Cursor at 0, press bntl with vblank=1 -> writes (0,000000) then (63,110000); cursor_pos=63. Then press bntr -> writes (63,000000) then (0,110000).
- bntr toggles every 2 cycles for 20 cycles, then stays low -> no request latched and no writes. bntl and bntr rise in the same cycle and are held -> no move.
- Two bntr presses while vblank=0 -> a single move 0 to 1 once vblank rises; the second press is dropped.
- Assert rst during WAIT_VB after a move to cell 5 -> outputs take reset values immediately. After release the full 64-write clear runs, the cursor is drawn at 0, and the pending request is gone.
